// File: rtl/tick_led_sequencer_if.sv
// ---------------------------------------------------------------------------
// tick_led_sequencer_if
//   Bundles the slow-clock input, the control inputs and the LED outputs of
//   tick_led_sequencer. The clock and reset stay plain ports on the module.
//
//   Signals
//     clk_slow    prescaler square wave, treated as an asynchronous level
//     en          1 = ticks advance pattern/count, 0 = freeze
//     mode        00 hold, 01 rotate left, 10 rotate right, 11 bounce
//     tick        1-cycle pulse per accepted rising edge of clk_slow
//     leds        current W-bit LED pattern
//     step_count  number of applied steps, wraps modulo 2^C
//
//   Modports
//     master  drives clk_slow/en/mode, observes tick/leds/step_count
//     slave   the sequencer itself
// ---------------------------------------------------------------------------
interface tick_led_sequencer_if #(
  parameter int W = 4,
  parameter int C = 8
);
  logic         clk_slow;
  logic         en;
  logic [1:0]   mode;
  logic         tick;
  logic [W-1:0] leds;
  logic [C-1:0] step_count;

  modport master (
    output clk_slow, en, mode,
    input  tick, leds, step_count
  );

  modport slave (
    input  clk_slow, en, mode,
    output tick, leds, step_count
  );
endinterface

// File: rtl/tick_led_sequencer.sv
// ---------------------------------------------------------------------------
// tick_led_sequencer
//   Synchronises the prescaler's slow square wave into the clk domain,
//   detects its rising edges and emits a registered 1-cycle tick per edge.
//   Each tick (when enabled and not in hold mode) advances a W-bit LED
//   pattern and increments a C-bit step counter.
//
//   Ports
//     clk   system clock, all state on posedge
//     rst   synchronous, active-high reset
//     bus   tick_led_sequencer_if.slave: clk_slow, en, mode in;
//           tick, leds, step_count out
//
//   Parameters
//     W     LED pattern width (>= 2)
//     C     step_count width
//     INIT  pattern loaded on reset
// ---------------------------------------------------------------------------
module tick_led_sequencer #(
  parameter int           W    = 4,
  parameter int           C    = 8,
  parameter logic [W-1:0] INIT = {{(W-1){1'b0}}, 1'b1}
) (
  input  logic                  clk,
  input  logic                  rst,
  tick_led_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_ROT_L  = 2'b01,
    MODE_ROT_R  = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  // Synchroniser and edge-detect state
  logic s1, s2, prev;
  // fill1/fill2 mark that s1/s2 hold a real post-reset sample of clk_slow,
  // so the reset value of s2 is never mistaken for a low level.
  logic fill1, fill2;
  logic armed;
  logic rise_det;

  // Pattern state
  logic         tick_q;
  logic [W-1:0] leds_q,  leds_nxt;
  logic [C-1:0] count_q, count_nxt;
  dir_t         dir_q,   dir_nxt;
  mode_t        mode;

  assign mode     = mode_t'(bus.mode);
  assign rise_det = s2 & ~prev & armed;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of the others (s1 -> s2 -> prev shifts
  // by exactly one stage per clock).
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      prev    <= 1'b0;
      fill1   <= 1'b0;
      fill2   <= 1'b0;
      armed   <= 1'b0;
      tick_q  <= 1'b0;
      leds_q  <= INIT;
      count_q <= '0;
      dir_q   <= DIR_LEFT;
    end else begin
      s1      <= bus.clk_slow;
      s2      <= s1;
      prev    <= s2;
      fill1   <= 1'b1;
      fill2   <= fill1;
      // A level held high through reset must first be seen low before any
      // rise can count.
      if (fill2 && !s2)
        armed <= 1'b1;
      tick_q  <= rise_det;
      leds_q  <= leds_nxt;
      count_q <= count_nxt;
      dir_q   <= dir_nxt;
    end
  end

  // NOTE: every output of this block gets a default first; without it a
  // path that skips an assignment would infer a latch.
  always_comb begin
    leds_nxt  = leds_q;
    count_nxt = count_q;
    dir_nxt   = dir_q;
    if (rise_det && bus.en && (mode != MODE_HOLD)) begin
      count_nxt = count_q + C'(1);
      case (mode)
        MODE_ROT_L: leds_nxt = {leds_q[W-2:0], leds_q[W-1]};
        MODE_ROT_R: leds_nxt = {leds_q[0], leds_q[W-1:1]};
        MODE_BOUNCE: begin
          // Zero-fill shifts: an all-zero pattern stays all-zero.
          case (dir_q)
            DIR_LEFT: begin
              if (leds_q[W-1]) begin
                dir_nxt  = DIR_RIGHT;
                leds_nxt = leds_q >> 1;
              end else begin
                leds_nxt = leds_q << 1;
              end
            end
            DIR_RIGHT: begin
              if (leds_q[0]) begin
                dir_nxt  = DIR_LEFT;
                leds_nxt = leds_q << 1;
              end else begin
                leds_nxt = leds_q >> 1;
              end
            end
            default: dir_nxt = DIR_LEFT;
          endcase
        end
        default: leds_nxt = leds_q;
      endcase
    end
  end

  assign bus.tick       = tick_q;
  assign bus.leds       = leds_q;
  assign bus.step_count = count_q;

endmodule

// File: tb/tb_tick_led_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tick_led_sequencer
//   Two instances: dut_a (W=4, C=8) exercises hold/rotate/bounce/freeze and
//   the held-through-reset case; dut_b (W=4, C=2) exercises counter wrap in
//   rotate-right mode. Stimulus pushes the expected {leds, step_count} for
//   each rise into a per-DUT queue; a monitor per DUT pops and compares on
//   every tick, and also checks that tick is one cycle wide.
// ---------------------------------------------------------------------------
module tb_tick_led_sequencer;

  typedef struct {
    logic [3:0] leds;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  tick_led_sequencer_if #(.W(4), .C(8)) bus_a ();
  tick_led_sequencer_if #(.W(4), .C(2)) bus_b ();

  tick_led_sequencer #(.W(4), .C(8), .INIT(4'b0001)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  tick_led_sequencer #(.W(4), .C(2), .INIT(4'b0001)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int   checks = 0;
  int   passes = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int   ticks_a = 0;
  int   ticks_b = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp)
      passes++;
    else
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
  endtask

  // ---------------- monitors ----------------
  logic prev_tick_a = 1'b0;
  exp_t e_a;
  always @(negedge clk) begin
    if (bus_a.tick === 1'b1) begin
      ticks_a++;
      check("a_tick_width", 32'(prev_tick_a), 32'd0);
      if (q_a.size() == 0) begin
        check("a_unexpected_tick", 32'd1, 32'd0);
      end else begin
        e_a = q_a.pop_front();
        check("a_leds", 32'(bus_a.leds), 32'(e_a.leds));
        check("a_step_count", 32'(bus_a.step_count), 32'(e_a.cnt));
      end
    end
    prev_tick_a = bus_a.tick;
  end

  logic prev_tick_b = 1'b0;
  exp_t e_b;
  always @(negedge clk) begin
    if (bus_b.tick === 1'b1) begin
      ticks_b++;
      check("b_tick_width", 32'(prev_tick_b), 32'd0);
      if (q_b.size() == 0) begin
        check("b_unexpected_tick", 32'd1, 32'd0);
      end else begin
        e_b = q_b.pop_front();
        check("b_leds", 32'(bus_b.leds), 32'(e_b.leds));
        check("b_step_count", 32'(bus_b.step_count), 32'(e_b.cnt));
      end
    end
    prev_tick_b = bus_b.tick;
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_slow(input bit sel, input logic v);
    if (sel) bus_b.clk_slow = v;
    else     bus_a.clk_slow = v;
  endtask

  // One prescaler-like period: 2 clk high, 2 clk low.
  task automatic rise(input bit sel, input logic [3:0] el, input logic [7:0] ec);
    exp_t e;
    e.leds = el;
    e.cnt  = ec;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
    @(posedge clk); #1;
    set_slow(sel, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    set_slow(sel, 1'b0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0] t2_leds [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [3:0] t3_leds [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                              4'b0010, 4'b0001, 4'b0010, 4'b0100};
  logic [3:0] t5_leds [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
  logic [7:0] t5_cnt  [5] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};

  initial begin
    int n;
    int t0;
    exp_t e;

    bus_a.clk_slow = 1'b0; bus_a.en = 1'b1; bus_a.mode = 2'b00;
    bus_b.clk_slow = 1'b0; bus_b.en = 1'b1; bus_b.mode = 2'b10;

    // 1: reset values and first-rise latency
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("a_reset_tick", 32'(bus_a.tick), 32'd0);
    check("a_reset_leds", 32'(bus_a.leds), 32'b0001);
    check("a_reset_count", 32'(bus_a.step_count), 32'd0);
    check("b_reset_leds", 32'(bus_b.leds), 32'b0001);
    check("b_reset_count", 32'(bus_b.step_count), 32'd0);

    repeat (4) @(posedge clk);
    e.leds = 4'b0001; e.cnt = 8'd0;
    q_a.push_back(e);
    #1;
    bus_a.clk_slow = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus_a.tick === 1'b1) break;
    end
    check("a_tick_latency", 32'(n), 32'd3);
    bus_a.clk_slow = 1'b0;
    repeat (3) @(posedge clk);

    // 2: rotate left, 5 rises
    bus_a.mode = 2'b01;
    for (int i = 0; i < 5; i++)
      rise(1'b0, t2_leds[i], 8'(i + 1));
    repeat (4) @(posedge clk);

    // 3: bounce from INIT, 8 rises
    do_reset();
    bus_a.mode = 2'b11;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 8; i++)
      rise(1'b0, t3_leds[i], 8'(i + 1));

    // 4: en=0 freezes pattern/count, ticks still emitted
    bus_a.en = 1'b0;
    t0 = ticks_a;
    for (int i = 0; i < 3; i++)
      rise(1'b0, 4'b0100, 8'd8);
    repeat (4) @(posedge clk);
    check("a_frozen_tick_count", 32'(ticks_a - t0), 32'd3);
    bus_a.en = 1'b1;
    rise(1'b0, 4'b1000, 8'd9);
    repeat (4) @(posedge clk);

    // 6: clk_slow held high through reset release
    bus_a.clk_slow = 1'b1;
    bus_a.mode = 2'b01;
    do_reset();
    t0 = ticks_a;
    repeat (10) @(posedge clk);
    #1;
    check("a_no_tick_after_reset_high", 32'(ticks_a - t0), 32'd0);
    bus_a.clk_slow = 1'b0;
    repeat (2) @(posedge clk);
    rise(1'b0, 4'b0010, 8'd1);
    repeat (4) @(posedge clk);
    check("a_one_tick_after_fall_rise", 32'(ticks_a - t0), 32'd1);

    // 5: C=2 wrap in rotate right
    for (int i = 0; i < 5; i++)
      rise(1'b1, t5_leds[i], t5_cnt[i]);

    // Drain
    for (int i = 0; i < 20; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);
    check("b_tick_total", 32'(ticks_b), 32'd5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
